// File: rtl/mac_seq.sv
// mac_seq: sequencer for one mac instance computing a LEN-term
// fixed-point dot product (one LSTM gate row).
//
// Ports:
//   clk, rst     clock (rising edge), synchronous active-high reset
//   i_start      start request, sampled only while idle
//   o_busy       high in CLR, RUN and DONE
//   o_mac_clr    clears the mac accumulator (drives mac rst)
//   o_acc        accumulate enable (drives mac acc)
//   o_addr       read address shared by the weight and input RAMs
//   i_mac        running sum from the mac (o_mac)
//   i_bias       bias added at DONE (only with MAC_SEQ_BIAS_EN)
//   o_result     latched dot-product result
//   o_valid      one-cycle pulse when o_result is updated
//
// Build option: define MAC_SEQ_BIAS_EN to add i_bias and a saturating
// bias add on the final sum. The FSM and timing do not change.
module mac_seq #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned FRAC   = 24,
   parameter int unsigned LEN    = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_mac_clr,
   output logic              o_acc,
   output logic [ADDR_W-1:0] o_addr,
   input  logic [WIDTH-1:0]  i_mac,
`ifdef MAC_SEQ_BIAS_EN
   input  logic [WIDTH-1:0]  i_bias,
`endif
   output logic [WIDTH-1:0]  o_result,
   output logic              o_valid
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CLR  = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [ADDR_W:0]   LAST   = (ADDR_W + 1)'(LEN - 1);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LEN - 1);

   logic [1:0]       state_q, state_d;
   logic [ADDR_W:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] done_val;

`ifdef MAC_SEQ_BIAS_EN
   // One guard bit is enough to see overflow of a two-operand add.
   logic [WIDTH:0] sum;

   always_comb begin
      sum = {i_mac[WIDTH-1], i_mac} + {i_bias[WIDTH-1], i_bias};
      if (sum[WIDTH] != sum[WIDTH-1]) begin
         if (sum[WIDTH])
            done_val = {1'b1, {(WIDTH-1){1'b0}}};
         else
            done_val = {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         done_val = sum[WIDTH-1:0];
      end
   end
`else
   assign done_val = i_mac;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      valid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start)
               state_d = CLR;
         end
         CLR: begin
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST)
               state_d = DONE;
         end
         DONE: begin
            result_d = done_val;
            valid_d  = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   // The address runs one element ahead of the data reaching the mac,
   // so RUN presents k+1 and holds the last index on the final cycle.
   always_comb begin
      o_addr = '0;
      if (state_q == RUN) begin
         if (cnt_q == LAST)
            o_addr = LAST_A;
         else
            o_addr = cnt_q[ADDR_W-1:0] + 1'b1;
      end
   end

   assign o_busy    = (state_q != IDLE);
   assign o_mac_clr = (state_q == CLR);
   assign o_acc     = (state_q == RUN);
   assign o_result  = result_q;
   assign o_valid   = valid_q;

endmodule
